// File: rtl/universal_shift_reg.sv
// universal_shift_reg: shift/rotate register with single-step and counted burst operation
module universal_shift_reg #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 4
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNTW-1:0]  cnt,
  output logic [WIDTH-1:0] Q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             zero,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state;
  logic [CNTW-1:0]   rem;
  logic [2:0]        lmode;
  logic [2:0]        sel;
  logic [WIDTH-1:0]  nxt;
  // next register value for the active operation: latched mode during a burst, live mode otherwise
  always_comb begin
    sel = (state == RUN) ? lmode : mode;
    nxt = (sel == 3'b001) ? {Q[WIDTH-2:0], sin_l} :
          (sel == 3'b010) ? {sin_r, Q[WIDTH-1:1]} :
          (sel == 3'b011) ? {Q[WIDTH-2:0], Q[WIDTH-1]} :
          (sel == 3'b100) ? {Q[0], Q[WIDTH-1:1]} :
          (sel == 3'b101) ? {Q[WIDTH-1], Q[WIDTH-1:1]} : Q;
  end
  // control FSM and data register; reset beats load, load beats any operation and aborts a burst
  always_ff @(posedge Clk) begin
    if (reset) begin
      Q     <= '0;
      state <= IDLE;
      rem   <= '0;
      lmode <= 3'b000;
    end else if (load) begin
      Q     <= D;
      state <= IDLE;
      rem   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (cnt != '0) begin
              lmode <= mode;
              rem   <= cnt;
              state <= RUN;
            end else begin
              state <= DONE;
            end
          end else if (en) begin
            Q <= nxt;
          end
        end
        RUN: begin
          Q   <= nxt;
          rem <= rem - CNTW'(1);
          if (rem == CNTW'(1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign zero   = (Q == '0);
  assign sout_l = Q[WIDTH-1];
  assign sout_r = Q[0];
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg: scoreboard bench with an arithmetic reference model and directed spec scenarios
module tb_universal_shift_reg;
  localparam int W = 4;
  localparam int C = 4;
  localparam int M = 1 << W;
  logic clk = 0, reset = 1, load = 0, en = 0, start = 0, sin_l = 0, sin_r = 0;
  logic [W-1:0] d = '0;
  logic [2:0] mode = 3'b000;
  logic [C-1:0] cnt = '0;
  logic [W-1:0] Q;
  logic sout_l, sout_r, zero, busy, done;
  int checks = 0, passed = 0;
  logic [W+4:0] sb[$];
  int mq = 0, mleft = 0, mlm = 0;
  bit mdone = 0;
  bit mdir;

  universal_shift_reg #(.WIDTH(W), .CNTW(C)) dut (
    .Clk(clk), .reset(reset), .load(load), .D(d), .en(en), .mode(mode),
    .sin_l(sin_l), .sin_r(sin_r), .start(start), .cnt(cnt), .Q(Q),
    .sout_l(sout_l), .sout_r(sout_r), .zero(zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int apply(int q, int m, int sl, int sr);
    case (m)
      1: return (q * 2 + sl) % M;
      2: return q / 2 + sr * (M / 2);
      3: return (q * 2) % M + q / (M / 2);
      4: return q / 2 + (q % 2) * (M / 2);
      5: return q / 2 + ((q >= M / 2) ? M / 2 : 0);
      default: return q;
    endcase
  endfunction

  task automatic cyc(input int r, input int l, input int dv, input int e, input int m,
                     input int sl, input int sr, input int st, input int c);
    logic [W-1:0] qv;
    @(negedge clk);
    reset = r[0]; load = l[0]; d = dv[W-1:0]; en = e[0]; mode = m[2:0];
    sin_l = sl[0]; sin_r = sr[0]; start = st[0]; cnt = c[C-1:0];
    if (r != 0) begin
      mq = 0; mleft = 0; mdone = 0; mlm = 0;
    end else if (l != 0) begin
      mq = dv % M; mleft = 0; mdone = 0;
    end else if (mdone) begin
      mdone = 0;
    end else if (mleft > 0) begin
      mq = apply(mq, mlm, sl, sr);
      mleft--;
      if (mleft == 0) mdone = 1;
    end else if (st != 0) begin
      if (c % (1 << C) > 0) begin
        mlm = m % 8; mleft = c % (1 << C);
      end else mdone = 1;
    end else if (e != 0) begin
      mq = apply(mq, m % 8, sl, sr);
    end
    qv = mq[W-1:0];
    sb.push_back({qv, mleft > 0, mdone, mq == 0, qv[W-1], qv[0]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input int q, input int b, input int dn);
    @(posedge clk);
    #2;
    checks++;
    if (Q == q[W-1:0] && busy == b[0] && done == dn[0]) passed++;
    else $display("FAIL %s: got Q=%b busy=%b done=%b, want Q=%b busy=%0d done=%0d",
                  name, Q, busy, done, q[W-1:0], b, dn);
  endtask

  initial begin
    logic [W+4:0] exp, act;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        act = {Q, busy, done, zero, sout_l, sout_r};
        checks++;
        if (act === exp) passed++;
        else $display("FAIL scoreboard @%0t: got {Q,busy,done,zero,sl,sr}=%b want %b", $time, act, exp);
      end
    end
  end

  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset", 0, 0, 0);
    cyc(1, 1, 9, 1, 1, 1, 1, 1, 3);
    chk("reset_hold", 0, 0, 0);
    cyc(0, 1, 5, 0, 0, 0, 0, 0, 0);
    chk("load_0101", 5, 0, 0);
    cyc(0, 0, 0, 1, 1, 1, 0, 0, 0);
    chk("shl_1011", 11, 0, 0);
    cyc(0, 0, 0, 1, 2, 0, 0, 0, 0);
    chk("shr_0101", 5, 0, 0);
    cyc(0, 1, 9, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 3, 0, 0, 1, 4);
    chk("burst_start", 9, 1, 0);
    cyc(0, 0, 0, 1, 1, 1, 1, 1, 7);
    chk("rotl_1", 3, 1, 0);
    cyc(0, 0, 0, 1, 2, 1, 1, 0, 0);
    chk("rotl_2", 6, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rotl_3", 12, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rotl_4_done", 9, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("after_done", 9, 0, 0);
    cyc(0, 1, 8, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 5, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 5, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 5, 0, 0, 0, 0);
    chk("ashr_1111", 15, 0, 0);
    cyc(0, 0, 0, 1, 6, 1, 1, 0, 0);
    chk("mode110_hold", 15, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 4, 0, 0, 1, 5);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 10, 0, 0, 0, 0, 0, 0);
    chk("abort_load", 10, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("abort_nodone", 10, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 1, 0);
    chk("cnt0_done", 10, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("cnt0_idle", 10, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0, 1, 6);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_midburst", 0, 0, 0);
    cyc(0, 1, 6, 0, 0, 0, 0, 1, 3);
    chk("load_beats_start", 6, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("no_burst", 6, 0, 0);
    cyc(0, 1, 9, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 4, 0, 0, 1, 15);
    idle(16);
    for (int i = 0; i < 600; i++) begin
      mdir = ($urandom_range(0, 1) == 1);
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, M - 1),
          $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1), mdir,
          $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, (1 << C) - 1));
    end
    idle(2);
    repeat (2) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 4: data register width, legal range 2..32.
REQ-002 Parameter CNTW, default 4: burst count width, legal range 1..8.
REQ-003 Clk  input  1: single clock, all state updates on its rising edge.
REQ-004 reset  input  1: synchronous, active-high reset, sampled on rising Clk.
REQ-005 load  input  1: parallel load strobe.
REQ-006 D  input  WIDTH: parallel load data.
REQ-007 en  input  1: single-step enable, used in IDLE only.
REQ-008 mode  input  3: operation select (codes in REQ-013).
REQ-009 sin_l  input  1: serial-in bit entering at the LSB on shift-left.
REQ-010 sin_r  input  1: serial-in bit entering at the MSB on shift-right.
REQ-011 start, cnt  input  1, CNTW: burst request and burst length.
REQ-012 Q  output  WIDTH: register contents; sout_l/sout_r output 1 = Q[WIDTH-1]/Q[0]; zero output 1 = (Q==0); busy output 1; done output 1.

Function
REQ-013 mode codes: 000 hold; 001 shl {Q[W-2:0],sin_l}; 010 shr {sin_r,Q[W-1:1]}; 011 rotl {Q[W-2:0],Q[W-1]}; 100 rotr {Q[0],Q[W-1:1]}; 101 ashr {Q[W-1],Q[W-1:1]}; 110/111 hold.
REQ-014 Per-edge priority: reset > load > burst/step operation.
REQ-015 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-016 IDLE, load=1: Q<=D next edge; start ignored that cycle; stay IDLE.
REQ-017 IDLE, load=0, start=1, cnt>0: latch mode and cnt, no Q change this edge, go RUN, busy=1 from next cycle.
REQ-018 IDLE, load=0, start=1, cnt=0: no shift, go DONE (done pulse next cycle).
REQ-019 IDLE, load=0, start=0, en=1: apply mode op to Q once; en=0: hold.
REQ-020 RUN: apply latched mode op every edge, decrement remaining count; edge that performs the last op (remaining==1) moves to DONE; exactly cnt ops total.
REQ-021 RUN ignores en, start, live mode and cnt; sin_l/sin_r are sampled live each edge.
REQ-022 RUN, load=1: Q<=D, burst aborted, go IDLE, no done pulse.
REQ-023 DONE: done=1 for exactly one cycle, Q holds, then IDLE; load in DONE loads Q, still returns to IDLE.
REQ-024 busy=1 iff state==RUN; done=1 iff state==DONE; both registered state decodes, no combinational path from inputs.
REQ-025 sout_l, sout_r, zero are combinational from Q only.
REQ-026 Burst length up to 2^CNTW-1 ops; rotations wrap without limit (cnt=WIDTH rotations restores Q).

Reset
REQ-027 reset=1 at a rising edge: Q<=0, state<=IDLE, remaining count<=0, latched mode<=000, regardless of load/start/state.
REQ-028 After reset: Q=0, zero=1, busy=0, done=0, sout_l=0, sout_r=0.
REQ-029 reset asserted during RUN aborts burst with no done pulse; reset held multiple cycles keeps all outputs at reset values.
REQ-030 No reset-release hazard: first edge with reset=0 follows normal priority.

Verification (WIDTH=4, CNTW=4)
REQ-031 reset; load=1 D=0101 -> Q=0101, zero=0; en=1 mode=001 sin_l=1 -> Q=1011; mode=010 sin_r=0 -> Q=0101.
REQ-032 Q=1001, start=1 cnt=4 mode=011 -> busy=1 for 4 cycles, Q sequence 0011,0110,1100,1001, then done=1 one cycle, busy=0.
REQ-033 Q=1000, en=1 mode=101 three edges -> Q=1100,1110,1111; mode=110 -> Q holds 1111.
REQ-034 Burst cnt=5 mode=100 from Q=0001, load=1 D=1010 on 3rd RUN cycle -> Q=1010, busy=0, done never asserted.
REQ-035 start=1 cnt=0 -> Q unchanged, done=1 on next cycle, busy never 1; reset asserted mid-burst (cnt=6) -> Q=0000, busy=0, done=0 next cycle.
REQ-036 load=1 and start=1 same IDLE edge with D=0110 -> Q=0110, state IDLE, no burst.
